// File: rtl/pc_unit.sv
// Program counter with a fetch-request FSM: issues PC as a fetch address,
// advances by STEP on each accepted handshake, and supports jump/flush and lock.
module pc_unit #(
    parameter int ADDR_W     = 32,
    parameter int STEP       = 4,
    parameter int RESET_ADDR = 0
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              i_pc_set_enable,
    input  logic              i_pc_address_enable,
    input  logic              i_pc_lock,
    input  logic [ADDR_W-1:0] i_set_addr,
    input  logic              i_mem_ready,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_address_valid,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_locked,
    output logic [15:0]       o_fetch_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] RESET_V = ADDR_W'(RESET_ADDR);

    state_t            state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [15:0]       count_reg;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_V;
            count_reg <= 16'd0;
        end else begin
            case (state_reg)
                REQ: begin
                    if (i_mem_ready) begin
                        // An accepted address always counts, whatever else is asserted.
                        count_reg <= count_reg + 16'd1;
                        pc_reg    <= i_pc_set_enable ? i_set_addr : pc_reg + STEP_V;
                        if (i_pc_lock)
                            state_reg <= LOCKED;
                        else if (i_pc_set_enable || !i_pc_address_enable)
                            state_reg <= IDLE;
                        else
                            state_reg <= REQ;
                    end else if (i_pc_lock) begin
                        state_reg <= LOCKED;
                    end else if (i_pc_set_enable) begin
                        pc_reg    <= i_set_addr;
                        state_reg <= IDLE;
                    end
                    // Otherwise the pending request holds, even if enable drops.
                end
                IDLE: begin
                    if (i_pc_lock)
                        state_reg <= LOCKED;
                    else if (i_pc_set_enable)
                        pc_reg <= i_set_addr;
                    else if (i_pc_address_enable)
                        state_reg <= REQ;
                end
                LOCKED: begin
                    if (!i_pc_lock)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_address       = pc_reg;
    assign o_pc            = pc_reg;
    assign o_address_valid = (state_reg == REQ);
    assign o_locked        = (state_reg == LOCKED);
    assign o_fetch_count   = count_reg;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: handshakes are checked by a scoreboard monitor,
// state/PC transitions by inline checks; an 8-bit instance covers wraparound.
module tb_pc_unit;

    logic        clk;
    logic        n_rst;
    logic        set_en, addr_en, lock, mem_ready;
    logic [31:0] set_addr;
    logic [31:0] address, pc;
    logic        address_valid, locked;
    logic [15:0] fetch_count;

    logic        set_en8, addr_en8, lock8, mem_ready8;
    logic [7:0]  set_addr8;
    logic [7:0]  address8, pc8;
    logic        address_valid8, locked8;
    logic [15:0] fetch_count8;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] cnt;
    } hs_t;
    hs_t sb[$];

    pc_unit #(.ADDR_W(32), .STEP(4), .RESET_ADDR(0)) dut (
        .clk(clk), .n_rst(n_rst),
        .i_pc_set_enable(set_en), .i_pc_address_enable(addr_en),
        .i_pc_lock(lock), .i_set_addr(set_addr), .i_mem_ready(mem_ready),
        .o_address(address), .o_address_valid(address_valid),
        .o_pc(pc), .o_locked(locked), .o_fetch_count(fetch_count)
    );

    pc_unit #(.ADDR_W(8), .STEP(4), .RESET_ADDR(0)) dut8 (
        .clk(clk), .n_rst(n_rst),
        .i_pc_set_enable(set_en8), .i_pc_address_enable(addr_en8),
        .i_pc_lock(lock8), .i_set_addr(set_addr8), .i_mem_ready(mem_ready8),
        .o_address(address8), .o_address_valid(address_valid8),
        .o_pc(pc8), .o_locked(locked8), .o_fetch_count(fetch_count8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_sample();
        step();
        @(negedge clk);
    endtask

    // Monitor: every accepted handshake is matched against the scoreboard.
    always @(negedge clk) begin
        if (n_rst === 1'b1 && address_valid === 1'b1 && mem_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL hs_unexpected: got handshake at 0x%0h, expected none", address);
            end else begin
                hs_t e;
                e = sb.pop_front();
                check("hs_addr", address, e.addr);
                check("hs_count_before", {16'd0, fetch_count}, {16'd0, e.cnt});
            end
        end
    end

    initial begin
        n_rst = 1'b0; set_en = 0; addr_en = 0; lock = 0; mem_ready = 0; set_addr = '0;
        set_en8 = 0; addr_en8 = 0; lock8 = 0; mem_ready8 = 0; set_addr8 = '0;

        // Reset
        step(); step_sample();
        check("rst_pc", pc, 32'h0);
        check("rst_valid", {31'd0, address_valid}, 32'd0);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_count", {16'd0, fetch_count}, 32'd0);

        // Back-to-back fetches
        step();
        n_rst = 1'b1; addr_en = 1; mem_ready = 1;
        sb.push_back('{32'h0, 16'd0});
        sb.push_back('{32'h4, 16'd1});
        sb.push_back('{32'h8, 16'd2});
        sb.push_back('{32'hC, 16'd3});
        step_sample();
        check("b2b_first_valid", {31'd0, address_valid}, 32'd1);
        check("b2b_first_count", {16'd0, fetch_count}, 32'd0);
        repeat (4) step();
        mem_ready = 0;
        @(negedge clk);
        check("b2b_pc", pc, 32'h10);
        check("b2b_count", {16'd0, fetch_count}, 32'd4);

        // Stall with enable dropped: address holds
        addr_en = 0;
        for (int i = 0; i < 3; i++) begin
            step_sample();
            check("stall_addr", address, 32'h10);
            check("stall_valid", {31'd0, address_valid}, 32'd1);
        end
        mem_ready = 1;
        sb.push_back('{32'h10, 16'd4});
        step();
        mem_ready = 0;
        @(negedge clk);
        check("stall_done_pc", pc, 32'h14);
        check("stall_done_valid", {31'd0, address_valid}, 32'd0);
        check("stall_done_count", {16'd0, fetch_count}, 32'd5);

        // Set in IDLE, then set+ready together in REQ
        set_en = 1; set_addr = 32'h20;
        step_sample();
        check("idle_set_pc", pc, 32'h20);
        check("idle_set_valid", {31'd0, address_valid}, 32'd0);
        set_en = 0; addr_en = 1;
        step_sample();
        check("req_at_20_valid", {31'd0, address_valid}, 32'd1);
        set_en = 1; set_addr = 32'h100; mem_ready = 1;
        sb.push_back('{32'h20, 16'd5});
        step();
        set_en = 0; mem_ready = 0;
        @(negedge clk);
        check("setready_pc", pc, 32'h100);
        check("setready_count", {16'd0, fetch_count}, 32'd6);
        check("setready_idle", {31'd0, address_valid}, 32'd0);

        // Lock from REQ without ready
        step_sample();
        check("req_at_100_valid", {31'd0, address_valid}, 32'd1);
        lock = 1;
        step_sample();
        check("lock_locked", {31'd0, locked}, 32'd1);
        check("lock_valid", {31'd0, address_valid}, 32'd0);
        check("lock_pc", pc, 32'h100);
        set_en = 1; set_addr = 32'h200;
        step_sample();
        check("lock_set_ignored_pc", pc, 32'h100);
        check("lock_set_still_locked", {31'd0, locked}, 32'd1);
        lock = 0; set_en = 0; addr_en = 0;
        step_sample();
        check("unlock_locked", {31'd0, locked}, 32'd0);
        check("unlock_valid", {31'd0, address_valid}, 32'd0);

        // Lock together with a completing handshake
        addr_en = 1;
        step();
        lock = 1; mem_ready = 1;
        sb.push_back('{32'h100, 16'd6});
        step();
        mem_ready = 0;
        @(negedge clk);
        check("hslock_locked", {31'd0, locked}, 32'd1);
        check("hslock_pc", pc, 32'h104);
        check("hslock_count", {16'd0, fetch_count}, 32'd7);
        lock = 0;
        step_sample();
        check("hslock_release", {31'd0, locked}, 32'd0);

        // Reset overrides a completing handshake
        step_sample();
        check("prerst_valid", {31'd0, address_valid}, 32'd1);
        step();
        mem_ready = 1; n_rst = 0;
        step();
        n_rst = 1; mem_ready = 0; addr_en = 0;
        @(negedge clk);
        check("midrst_pc", pc, 32'h0);
        check("midrst_count", {16'd0, fetch_count}, 32'd0);
        check("midrst_valid", {31'd0, address_valid}, 32'd0);

        // 8-bit PC wrap and 16-bit count wrap
        set_en8 = 1; set_addr8 = 8'hFC;
        step();
        set_en8 = 0; addr_en8 = 1; mem_ready8 = 1;
        step_sample();
        check("w8_pc_fc", {24'd0, pc8}, 32'hFC);
        step_sample();
        check("w8_pc_wrap", {24'd0, pc8}, 32'h00);
        check("w8_count1", {16'd0, fetch_count8}, 32'd1);
        repeat (65534) step();
        @(negedge clk);
        check("w8_count_max", {16'd0, fetch_count8}, 32'hFFFF);
        step_sample();
        check("w8_count_wrap", {16'd0, fetch_count8}, 32'h0000);
        addr_en8 = 0; mem_ready8 = 0;

        check("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameters (name, default, meaning): ADDR_W, 32, address width; STEP, 4, byte increment per fetch; RESET_ADDR, 0, PC value after reset.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 n_rst  input  1  reset, synchronous, active-low.
REQ-004 i_pc_set_enable  input  1  load PC from i_set_addr (jump/flush).
REQ-005 i_pc_address_enable  input  1  permission to issue fetch addresses.
REQ-006 i_pc_lock  input  1  freeze PC and suppress address output.
REQ-007 i_set_addr  input  ADDR_W  jump target.
REQ-008 i_mem_ready  input  1  memory accepts the presented address this cycle.
REQ-009 o_address  output  ADDR_W  fetch address; equals PC register.
REQ-010 o_address_valid  output  1  fetch request active; high only in state REQ.
REQ-011 o_pc  output  ADDR_W  current PC register.
REQ-012 o_locked  output  1  high only in state LOCKED.
REQ-013 o_fetch_count  output  16  completed handshakes, wraps 0xFFFF->0x0000.

Function
REQ-014 The FSM SHALL have states IDLE, REQ and LOCKED; o_address_valid and o_locked SHALL decode from the state register only.
REQ-015 The per-cycle priority SHALL be: reset > completing handshake (REQ and i_mem_ready) > lock > set > address_enable.
REQ-016 A handshake SHALL complete on any cycle in REQ with i_mem_ready=1, regardless of the other inputs, and SHALL increment o_fetch_count by 1.
REQ-017 On handshake completion, PC SHALL become PC+STEP modulo 2^ADDR_W, or i_set_addr if i_pc_set_enable=1 in the same cycle (set wins over increment).
REQ-018 On handshake completion, next state SHALL be LOCKED if i_pc_lock=1, else IDLE if i_pc_set_enable=1 or i_pc_address_enable=0, else REQ (back-to-back fetch, valid held high).
REQ-019 In IDLE: i_pc_lock=1 -> LOCKED, PC held; else i_pc_set_enable=1 -> PC<=i_set_addr, stay IDLE; else i_pc_address_enable=1 -> REQ; else stay IDLE.
REQ-020 IDLE->REQ latency SHALL be one cycle: enable sampled at edge N, o_address_valid high after edge N.
REQ-021 In REQ without i_mem_ready: i_pc_lock=1 -> LOCKED (request dropped); else i_pc_set_enable=1 -> PC<=i_set_addr, IDLE (request flushed); else remain REQ with o_address stable, even if i_pc_address_enable falls.
REQ-022 In LOCKED: PC SHALL be held, and i_pc_set_enable and i_pc_address_enable SHALL be ignored; i_pc_lock=0 -> IDLE.
REQ-023 o_address SHALL never change while o_address_valid=1 and i_mem_ready=0.
REQ-024 PC SHALL change only via REQ-017, REQ-019 or REQ-021.

Reset
REQ-025 When n_rst=0 at a clock edge: PC=RESET_ADDR, state IDLE, o_address_valid=0, o_locked=0, o_fetch_count=0, overriding all other inputs including a completing handshake.
REQ-026 Before the first edge with n_rst=0, outputs are undefined; the bench SHALL check outputs only after it.

Verification
REQ-027 Reset, enable=1, ready=1 continuously -> valid from the 2nd cycle; o_address 0x0, 0x4, 0x8, one per cycle; count 1, 2, 3.
REQ-028 PC=0x10 in REQ, ready=0 for 3 cycles, enable dropped -> address held 0x10; ready=1 -> PC=0x14, IDLE, count+1.
REQ-029 In REQ at PC=0x20, set=1, set_addr=0x100, ready=1 same cycle -> count+1, PC=0x100, IDLE (no 0x24).
REQ-030 In REQ, lock=1, ready=0 -> LOCKED next cycle, valid=0, PC unchanged; set=1 while locked -> ignored; lock=0 -> IDLE.
REQ-031 ADDR_W=8, PC=0xFC, handshake -> PC=0x00; count at 0xFFFF plus handshake -> 0x0000.
REQ-032 n_rst=0 during REQ with ready=1 -> next cycle PC=RESET_ADDR, count=0, valid=0.
